// File: rtl/serial_addsub_mux.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// The single bit cell is built only from mux_2x1 instances; carry/borrow is registered.

module mux_2x1 (
  input  logic [1:0] i,
  input  logic       s,
  output logic       y
);
  assign y = i[s];
endmodule

module serial_addsub_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cbin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cbout,
  output logic             zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             mode_r, cy_reg;
  logic [CNT_W-1:0] cnt;

  logic x, y, c;
  logic p, s_bit, xg, gen, pc, c_next;
  logic [WIDTH-1:0] res_next;

  assign x = a_sr[0];
  assign y = b_sr[0];
  assign c = cy_reg;

  mux_2x1 u_xor_xy  (.i({~y, y}),     .s(x),      .y(p));
  mux_2x1 u_xor_sum (.i({~c, c}),     .s(p),      .y(s_bit));
  // add generates on x&y, subtract on ~x&y: mode picks the polarity of x
  mux_2x1 u_xsel    (.i({x, ~x}),     .s(mode_r), .y(xg));
  mux_2x1 u_gen     (.i({y, 1'b0}),   .s(xg),     .y(gen));
  mux_2x1 u_psel    (.i({~p, p}),     .s(mode_r), .y(pc));
  mux_2x1 u_carry   (.i({gen, c}),    .s(pc),     .y(c_next));

  assign res_next = {s_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      mode_r <= 1'b0;
      cy_reg <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cbout  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            mode_r <= mode;
            cy_reg <= cbin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          cy_reg <= c_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= res_next;
            cbout  <= c_next;
            zero   <= ~|res_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub_mux.sv
// Scoreboard bench for serial_addsub_mux: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.

module tb_serial_addsub_mux;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cbin = 1'b0;
  logic         busy, done, cbout, zero;
  logic [W-1:0] result;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cb;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  serial_addsub_mux #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .cbin(cbin), .busy(busy), .done(done), .result(result),
    .cbout(cbout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cbout", 32'(cbout), 32'(e.cb));
        chk("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  // Drive at a negedge, hold start over one rising edge, return at the next negedge.
  task automatic issue(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic [W-1:0] er, input logic ecb);
    exp_t e;
    mode = m; a = av; b = bv; cbin = ci; start = 1'b1;
    e.res = er; e.cb = ecb; e.z = (er == '0);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) nbusy++;
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  int nb;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cbout", 32'(cbout), 0);
    chk("rst_zero", 32'(zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // basic subtract with latency check
    issue(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    wait_done(nb);
    chk("latency_busy_cycles", 32'(nb), 32'd8);
    chk("done_one_cycle", 32'(done), 32'd0);

    issue(1'b0, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1); wait_done(nb);
    issue(1'b0, 8'h33, 8'h33, 1'b0, 8'h00, 1'b0); wait_done(nb);
    issue(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1); wait_done(nb);
    issue(1'b1, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1); wait_done(nb);
    issue(1'b1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0); wait_done(nb);
    issue(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1); wait_done(nb);
    chk("result_held_idle", 32'(result), 32'hFF);

    // start pulse during SHIFT must be ignored
    issue(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    @(negedge clk);
    @(negedge clk);
    mode = 1'b1; a = 8'hFF; b = 8'h00; cbin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    repeat (12) @(negedge clk);

    // back-to-back: start held through DONE
    mode = 1'b0; a = 8'h5A; b = 8'h3C; cbin = 1'b0; start = 1'b1;
    sb.push_back('{res: 8'h1E, cb: 1'b0, z: 1'b0});
    begin : b2b
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (done) begin seen = 1; break; end
      end
      chk("b2b_first_done", 32'(seen), 32'd1);
    end
    a = 8'h01; b = 8'h02;
    sb.push_back('{res: 8'hFF, cb: 1'b1, z: 1'b0});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    wait_done(nb);
    chk("b2b_busy_cycles", 32'(nb), 32'd8);

    // async reset mid-operation
    issue(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_cbout", 32'(cbout), 0);
    chk("arst_zero", 32'(zero), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    wait_done(nb);
    chk("post_rst_busy_cycles", 32'(nb), 32'd8);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
